// File: rtl/button_pio_debounced.sv
// Avalon-MM button/switch PIO: per-channel two-flop sync, counter debounce,
// selectable rise/fall edge capture with write-1-to-clear and a maskable level irq.
module button_pio_debounced #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_LEVEL   = 3'd0;
  localparam logic [2:0] ADDR_RAW     = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN = 3'd5;

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] stable, stable_d;
  logic [CNT_W-1:0] cnt [WIDTH];

  logic [WIDTH-1:0] irq_mask, edge_capture, rise_en, fall_en;
  logic [WIDTH-1:0] wdata, edge_event, clear_bits;
  logic             wr_strobe;
  logic [31:0]      read_mux;
  logic             unused_wdata;

  assign wr_strobe    = chipselect && !write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Synchroniser and per-channel debounce counters.
  // NOTE: every register here, counters included, uses <= so that all of them
  // sample the values from before the clock edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // cleared element by element; a partial count must not survive reset.
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1    <= in_port;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign edge_event = (stable & ~stable_d & rise_en) | (~stable & stable_d & fall_en);
  assign clear_bits = (wr_strobe && address == ADDR_CAPTURE) ? wdata : '0;

  // A fresh event wins over a same-cycle clear so no edge is ever lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      rise_en      <= '1;
      fall_en      <= '0;
    end else begin
      edge_capture <= edge_event | (edge_capture & ~clear_bits);
      if (wr_strobe) begin
        case (address)
          ADDR_MASK:    irq_mask <= wdata;
          ADDR_RISE_EN: rise_en  <= wdata;
          ADDR_FALL_EN: fall_en  <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns read_mux and no latch is inferred.
    read_mux = '0;
    case (address)
      ADDR_LEVEL:   read_mux[WIDTH-1:0] = stable;
      ADDR_RAW:     read_mux[WIDTH-1:0] = sync2;
      ADDR_MASK:    read_mux[WIDTH-1:0] = irq_mask;
      ADDR_CAPTURE: read_mux[WIDTH-1:0] = edge_capture;
      ADDR_RISE_EN: read_mux[WIDTH-1:0] = rise_en;
      ADDR_FALL_EN: read_mux[WIDTH-1:0] = fall_en;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= read_mux;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_button_pio_debounced.sv
// Self-checking bench for button_pio_debounced: register table, directed timing
// sequences, and randomized traffic against a window-based reference model.
module tb_button_pio_debounced;

  localparam int W = 3;
  localparam int D = 4;

  logic          clk;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;

  button_pio_debounced #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last D synchronised samples
  // all disagree with the current debounced level; an accepted change is
  // reported as an edge one cycle later.
  logic [W-1:0] pq[$];
  logic [W-1:0] m_stable, m_rise_pend, m_fall_pend;
  logic [W-1:0] m_mask, m_cap, m_rise_en, m_fall_en;
  logic [W-1:0] m_s2, m_ev, m_and, m_or, m_flip, m_clr, m_wd;
  logic [31:0]  m_rd;
  bit           m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      pq.delete();
      repeat (D + 2) pq.push_back('0);
      m_stable = '0; m_rise_pend = '0; m_fall_pend = '0;
      m_mask = '0; m_cap = '0; m_rise_en = '1; m_fall_en = '0;
      m_rd = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_s2 = pq[pq.size() - 2];
      m_and = '1;
      m_or  = '0;
      for (int j = 1; j <= D; j++) begin
        m_and = m_and & pq[pq.size() - 1 - j];
        m_or  = m_or  | pq[pq.size() - 1 - j];
      end
      m_flip = (~m_stable & m_and) | (m_stable & ~m_or);

      case (address)
        3'd0:    m_rd = 32'(m_stable);
        3'd1:    m_rd = 32'(m_s2);
        3'd2:    m_rd = 32'(m_mask);
        3'd3:    m_rd = 32'(m_cap);
        3'd4:    m_rd = 32'(m_rise_en);
        3'd5:    m_rd = 32'(m_fall_en);
        default: m_rd = 32'd0;
      endcase

      m_wd  = writedata[W-1:0];
      m_ev  = (m_rise_pend & m_rise_en) | (m_fall_pend & m_fall_en);
      m_clr = (chipselect && !write_n && address == 3'd3) ? m_wd : '0;
      m_cap = m_ev | (m_cap & ~m_clr);
      if (chipselect && !write_n) begin
        if (address == 3'd2) m_mask    = m_wd;
        if (address == 3'd4) m_rise_en = m_wd;
        if (address == 3'd5) m_fall_en = m_wd;
      end

      m_rise_pend = m_flip & ~m_stable;
      m_fall_pend = m_flip & m_stable;
      m_stable    = m_stable ^ m_flip;

      pq.push_back(in_port);
      if (pq.size() > D + 4) void'(pq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_rd", readdata, m_rd);
      check("model_irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    end
  end

  // Bus helpers: all are entered just after a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic wr, input logic [2:0] a, input logic [31:0] d, input string n);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.name = n;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] rd;

    add_vec(0, 3'd0, 32'h0, "rst_level");
    add_vec(0, 3'd1, 32'h0, "rst_raw");
    add_vec(0, 3'd2, 32'h0, "rst_mask");
    add_vec(0, 3'd3, 32'h0, "rst_cap");
    add_vec(0, 3'd4, 32'h7, "rst_rise_en");
    add_vec(0, 3'd5, 32'h0, "rst_fall_en");
    add_vec(0, 3'd6, 32'h0, "rst_addr6");
    add_vec(0, 3'd7, 32'h0, "rst_addr7");
    add_vec(1, 3'd2, 32'hFFFF_FFF5, "");
    add_vec(0, 3'd2, 32'h5, "mask_rw_upper_ignored");
    add_vec(1, 3'd4, 32'h2, "");
    add_vec(0, 3'd4, 32'h2, "rise_en_rw");
    add_vec(1, 3'd0, 32'h7, "");
    add_vec(0, 3'd0, 32'h0, "ro_level_write_ignored");
    add_vec(1, 3'd6, 32'hFF, "");
    add_vec(0, 3'd6, 32'h0, "addr6_write_ignored");
    add_vec(1, 3'd5, 32'h3, "");
    add_vec(0, 3'd5, 32'h3, "fall_en_rw");
    add_vec(1, 3'd2, 32'h0, "");
    add_vec(1, 3'd4, 32'h7, "");
    add_vec(1, 3'd5, 32'h0, "");
    add_vec(0, 3'd3, 32'h0, "cap_still_clear");

    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    address = 3'd0; writedata = '0; in_port = '0;
    tick(2);
    reset = 1'b0;
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_readdata", readdata, 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else begin
        bus_read(vecs[i].addr, rd);
        check(vecs[i].name, rd, vecs[i].data);
      end
    end

    // Debounce latency: stable at edge D+1, capture at edge D+2.
    bus_write(3'd2, 32'h1);
    address = 3'd0;
    in_port = 3'b001;
    for (int k = 0; k <= D + 2; k++) begin
      @(negedge clk);
      if (k == D + 1) begin
        check("lat_level_before", readdata, 32'h0);
        check("lat_irq_before", {31'b0, irq}, 32'd0);
      end
      if (k == D + 2) begin
        check("lat_level_after", readdata, 32'h1);
        check("lat_irq_after", {31'b0, irq}, 32'd1);
      end
    end
    bus_write(3'd3, 32'h7);
    check("lat_irq_cleared", {31'b0, irq}, 32'd0);

    // Short glitch on bit2 must be rejected.
    in_port = 3'b101;
    tick(D - 1);
    in_port = 3'b001;
    tick(D + 4);
    bus_read(3'd0, rd); check("glitch_level", rd, 32'h1);
    bus_read(3'd3, rd); check("glitch_cap", rd, 32'h0);

    // Falling-only on bit1.
    bus_write(3'd4, 32'h0);
    bus_write(3'd5, 32'h2);
    in_port = 3'b010;
    tick(20);
    bus_read(3'd3, rd); check("fall_only_press", rd, 32'h0);
    in_port = 3'b000;
    tick(D + 3);
    bus_read(3'd3, rd); check("fall_only_release", rd, 32'h2);
    check("fall_only_irq_masked", {31'b0, irq}, 32'd0);
    bus_write(3'd4, 32'h7);
    bus_write(3'd5, 32'h0);
    bus_write(3'd3, 32'h7);

    // IRQ and write-1-to-clear.
    bus_write(3'd2, 32'h5);
    in_port = 3'b111;
    tick(D + 3);
    bus_read(3'd3, rd); check("irq_cap_all", rd, 32'h7);
    check("irq_set", {31'b0, irq}, 32'd1);
    bus_write(3'd3, 32'h5);
    check("w1c_read_pre", readdata, 32'h7);
    check("w1c_irq_fall", {31'b0, irq}, 32'd0);
    tick(1);
    check("w1c_read_post", readdata, 32'h2);
    bus_write(3'd3, 32'h2);
    tick(1);
    check("w1c_clear_rest", readdata, 32'h0);

    // Collision: clear of bit0 on the same edge as a new bit0 rising event.
    bus_write(3'd5, 32'h1);
    in_port = 3'b110;
    tick(D + 3);
    check("coll_pre_irq", {31'b0, irq}, 32'd1);
    in_port = 3'b111;
    tick(D + 2);
    bus_write(3'd3, 32'h1);
    check("coll_irq", {31'b0, irq}, 32'd1);
    tick(1);
    check("coll_cap", readdata, 32'h1);
    bus_write(3'd5, 32'h0);
    in_port = 3'b000;
    tick(D + 4);
    bus_write(3'd3, 32'h7);

    // Reset in the middle of a debounce count.
    in_port = 3'b001;
    tick(D);
    address = 3'd0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_mid_rd", readdata, 32'h0);
    tick(D + 2);
    check("rst_mid_pre", readdata, 32'h0);
    tick(1);
    check("rst_mid_accept", readdata, 32'h1);
    check("rst_mid_irq_pre", {31'b0, irq}, 32'd0);
    bus_read(3'd3, rd); check("rst_mid_cap", rd, 32'h1);
    check("rst_mid_irq", {31'b0, irq}, 32'd0);

    // Randomized traffic; the model comparison runs on every falling edge.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) in_port[b] = ~in_port[b];
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      reset      = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
